// File: rtl/wb_write_arbiter_if.sv
// ----------------------------------------------------------------------------
// wb_write_arbiter_if
// Bundles the writeback arbiter's handshake and register-file signals.
//   a_valid_i/a_rd_i/a_wd_i -> a_ready_o   : in-order pipeline writeback (source A)
//   b_valid_i/b_rd_i/b_wd_i -> b_ready_o   : long-latency unit results (source B)
//   regwrite_o/rd_o/wd_o                   : register file write port
//   pending_o                              : registers with a write still in flight
// Signal suffixes are from the arbiter's point of view.
// Modports: master = sources and register file side, slave = the arbiter.
// ----------------------------------------------------------------------------
interface wb_write_arbiter_if #(
    parameter int XLEN = 32
);
    logic            a_valid_i;
    logic [4:0]      a_rd_i;
    logic [XLEN-1:0] a_wd_i;
    logic            a_ready_o;
    logic            b_valid_i;
    logic [4:0]      b_rd_i;
    logic [XLEN-1:0] b_wd_i;
    logic            b_ready_o;
    logic            regwrite_o;
    logic [4:0]      rd_o;
    logic [XLEN-1:0] wd_o;
    logic [31:0]     pending_o;

    modport master (
        output a_valid_i, a_rd_i, a_wd_i,
        input  a_ready_o,
        output b_valid_i, b_rd_i, b_wd_i,
        input  b_ready_o,
        input  regwrite_o, rd_o, wd_o, pending_o
    );

    modport slave (
        input  a_valid_i, a_rd_i, a_wd_i,
        output a_ready_o,
        input  b_valid_i, b_rd_i, b_wd_i,
        output b_ready_o,
        output regwrite_o, rd_o, wd_o, pending_o
    );
endinterface

// File: rtl/wb_write_arbiter.sv
// ----------------------------------------------------------------------------
// wb_write_arbiter
// Single register-file write port shared by the in-order writeback (A) and a
// long-latency unit (B). B results are queued in a DEPTH-entry FIFO. A wins by
// default; the FIFO head wins when A is idle or when the head has waited
// STARVE_MAX cycles. Writes to x0 complete their handshake but are dropped.
// Ports:
//   clk_i    : clock, rising edge
//   reset_i  : asynchronous active-low reset
//   bus      : wb_write_arbiter_if.slave (A/B handshakes, write port, pending mask)
// ----------------------------------------------------------------------------
module wb_write_arbiter #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    wb_write_arbiter_if.slave bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int WAIT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_MAX);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

    // One-hot decode of a destination register; x0 never marks a hazard.
    function automatic logic [31:0] onehot_rd(input logic [4:0] r);
        logic [31:0] m;
        m = 32'd1 << r;
        return m & ~32'd1;
    endfunction

    logic [4:0]        fifo_rd_q [DEPTH];
    logic [XLEN-1:0]   fifo_wd_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, rptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              regwrite_q, regwrite_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   wd_q, wd_d;

    logic        empty_s, starve_s, pop_s, push_s, a_fire_s;
    logic [31:0] pending_s;

    // Grant decision: starvation pre-empts A, otherwise A, otherwise FIFO head.
    always_comb begin
        empty_s  = (count_q == CNT_ZERO);
        starve_s = !empty_s && (wait_q >= WAIT_MAX);
        pop_s    = starve_s || (!empty_s && !bus.a_valid_i);
        a_fire_s = bus.a_valid_i && !starve_s;
        // x0 results complete the handshake but never occupy a FIFO slot.
        push_s   = bus.b_valid_i && (count_q != CNT_FULL) && (bus.b_rd_i != 5'd0);
    end

    // Next-state for occupancy, head wait counter and the output stage.
    always_comb begin
        count_d    = count_q;
        wait_d     = wait_q;
        regwrite_d = 1'b0;
        rd_d       = rd_q;
        wd_d       = wd_q;

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (pop_s || empty_s) begin
            wait_d = {WAIT_W{1'b0}};
        end else if (wait_q < WAIT_MAX) begin
            wait_d = wait_q + WAIT_ONE;
        end else begin
            wait_d = wait_q;
        end

        // FIFO entries are never x0, so a pop always produces a real write.
        if (pop_s) begin
            regwrite_d = 1'b1;
            rd_d       = fifo_rd_q[rptr_q];
            wd_d       = fifo_wd_q[rptr_q];
        end else if (a_fire_s && (bus.a_rd_i != 5'd0)) begin
            regwrite_d = 1'b1;
            rd_d       = bus.a_rd_i;
            wd_d       = bus.a_wd_i;
        end else begin
            regwrite_d = 1'b0;
        end
    end

    // Hazard mask: every queued destination plus the one being written now.
    always_comb begin
        pending_s = 32'd0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CNT_W'(k) < count_q) begin
                pending_s = pending_s | onehot_rd(fifo_rd_q[rptr_q + PTR_W'(k)]);
            end else begin
                pending_s = pending_s;
            end
        end
        if (regwrite_q) begin
            pending_s = pending_s | onehot_rd(rd_q);
        end else begin
            pending_s = pending_s;
        end
    end

    // Control state and registered write port.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            count_q    <= CNT_ZERO;
            wait_q     <= {WAIT_W{1'b0}};
            wptr_q     <= {PTR_W{1'b0}};
            rptr_q     <= {PTR_W{1'b0}};
            regwrite_q <= 1'b0;
            rd_q       <= 5'd0;
            wd_q       <= {XLEN{1'b0}};
        end else begin
            count_q    <= count_d;
            wait_q     <= wait_d;
            wptr_q     <= push_s ? (wptr_q + PTR_ONE) : wptr_q;
            rptr_q     <= pop_s  ? (rptr_q + PTR_ONE) : rptr_q;
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            wd_q       <= wd_d;
        end
    end

    // FIFO storage; cleared on reset so stale entries can never resurface.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_rd_q[i] <= 5'd0;
                fifo_wd_q[i] <= {XLEN{1'b0}};
            end
        end else if (push_s) begin
            fifo_rd_q[wptr_q] <= bus.b_rd_i;
            fifo_wd_q[wptr_q] <= bus.b_wd_i;
        end
    end

    assign bus.a_ready_o  = !starve_s;
    assign bus.b_ready_o  = (count_q != CNT_FULL);
    assign bus.regwrite_o = regwrite_q;
    assign bus.rd_o       = rd_q;
    assign bus.wd_o       = wd_q;
    assign bus.pending_o  = pending_s;
endmodule

// File: tb/tb_wb_write_arbiter.sv
// ----------------------------------------------------------------------------
// tb_wb_write_arbiter
// Directed scenarios with hand-derived expectations, followed by a random run
// compared cycle by cycle against a queue-based reference of the arbitration
// rules (A first, FIFO head when A idle or after STARVE_MAX waiting cycles).
// ----------------------------------------------------------------------------
module tb_wb_write_arbiter;
    localparam int XLEN       = 32;
    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] wd;
    } ent_t;

    logic clk;
    logic reset_i;
    int   n_checks = 0;
    int   n_fail   = 0;

    wb_write_arbiter_if #(.XLEN(XLEN)) bus_if ();

    wb_write_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state
    ent_t        mq[$];
    int          m_wait;
    logic        m_rw;
    logic [4:0]  m_rd;
    logic [31:0] m_wd;
    bit          last_a_acc, last_b_acc;

    task automatic model_clear();
        mq.delete();
        m_wait = 0;
        m_rw   = 1'b0;
        m_rd   = 5'd0;
        m_wd   = 32'd0;
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] p;
        p = 32'd0;
        foreach (mq[i]) p[mq[i].rd] = 1'b1;
        if (m_rw) p[m_rd] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    task automatic idle_inputs();
        bus_if.a_valid_i = 1'b0;
        bus_if.a_rd_i    = 5'd0;
        bus_if.a_wd_i    = 32'd0;
        bus_if.b_valid_i = 1'b0;
        bus_if.b_rd_i    = 5'd0;
        bus_if.b_wd_i    = 32'd0;
    endtask

    // Advance one clock edge, applying the arbitration rules to the reference.
    task automatic tick();
        ent_t e;
        bit   was_empty, starve, pop;
        was_empty  = (mq.size() == 0);
        starve     = !was_empty && (m_wait >= STARVE_MAX);
        pop        = starve || (!was_empty && !bus_if.a_valid_i);
        last_a_acc = bus_if.a_valid_i && !starve;
        last_b_acc = bus_if.b_valid_i && (mq.size() != DEPTH);
        if (pop) begin
            e    = mq.pop_front();
            m_rw = 1'b1;
            m_rd = e.rd;
            m_wd = e.wd;
        end else if (last_a_acc && bus_if.a_rd_i != 5'd0) begin
            m_rw = 1'b1;
            m_rd = bus_if.a_rd_i;
            m_wd = bus_if.a_wd_i;
        end else begin
            m_rw = 1'b0;
        end
        if (pop || was_empty) m_wait = 0;
        else if (m_wait < STARVE_MAX) m_wait = m_wait + 1;
        if (last_b_acc && bus_if.b_rd_i != 5'd0) begin
            e.rd = bus_if.b_rd_i;
            e.wd = bus_if.b_wd_i;
            mq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b0;
        idle_inputs();
        model_clear();
        #2;
        reset_i = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b0;
        idle_inputs();
        model_clear();
        #3;
        n_checks++; if (bus_if.regwrite_o !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite: got %b want 0", bus_if.regwrite_o); end
        n_checks++; if (bus_if.rd_o !== 5'd0) begin n_fail++; $display("FAIL reset_rd: got %0d want 0", bus_if.rd_o); end
        n_checks++; if (bus_if.wd_o !== 32'd0) begin n_fail++; $display("FAIL reset_wd: got %h want 0", bus_if.wd_o); end
        n_checks++; if (bus_if.pending_o !== 32'd0) begin n_fail++; $display("FAIL reset_pending: got %h want 0", bus_if.pending_o); end
        n_checks++; if (bus_if.a_ready_o !== 1'b1 || bus_if.b_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got a=%b b=%b want 1/1", bus_if.a_ready_o, bus_if.b_ready_o); end
        #4;
        reset_i = 1'b1;
    endtask

    task automatic test_a_only();
        do_reset();
        bus_if.a_valid_i = 1'b1; bus_if.a_rd_i = 5'd5; bus_if.a_wd_i = 32'hDEADBEEF;
        n_checks++; if (bus_if.a_ready_o !== 1'b1) begin n_fail++; $display("FAIL a_only_ready0: got %b want 1", bus_if.a_ready_o); end
        tick();
        n_checks++; if (bus_if.regwrite_o !== 1'b1 || bus_if.rd_o !== 5'd5 || bus_if.wd_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL a_only_w0: got rw=%b rd=%0d wd=%h want 1/5/deadbeef", bus_if.regwrite_o, bus_if.rd_o, bus_if.wd_o); end
        bus_if.a_rd_i = 5'd6; bus_if.a_wd_i = 32'h1;
        n_checks++; if (bus_if.a_ready_o !== 1'b1) begin n_fail++; $display("FAIL a_only_ready1: got %b want 1", bus_if.a_ready_o); end
        tick();
        n_checks++; if (bus_if.regwrite_o !== 1'b1 || bus_if.rd_o !== 5'd6 || bus_if.wd_o !== 32'h1) begin n_fail++; $display("FAIL a_only_w1: got rw=%b rd=%0d wd=%h want 1/6/1", bus_if.regwrite_o, bus_if.rd_o, bus_if.wd_o); end
        n_checks++; if (bus_if.pending_o !== 32'h40) begin n_fail++; $display("FAIL a_only_pend: got %h want 40", bus_if.pending_o); end
        idle_inputs();
        tick();
        n_checks++; if (bus_if.regwrite_o !== 1'b0) begin n_fail++; $display("FAIL a_only_idle: got %b want 0", bus_if.regwrite_o); end
    endtask

    task automatic test_b_only();
        logic [4:0]  exp_rd [4]  = '{5'd0, 5'd7, 5'd8, 5'd9};
        logic [31:0] exp_wd [4]  = '{32'h0, 32'h11, 32'h22, 32'h33};
        logic [31:0] exp_pd [5]  = '{32'h080, 32'h180, 32'h300, 32'h200, 32'h000};
        logic [4:0]  push_rd [3] = '{5'd7, 5'd8, 5'd9};
        logic [31:0] push_wd [3] = '{32'h11, 32'h22, 32'h33};
        do_reset();
        for (int s = 0; s < 5; s++) begin
            if (s < 3) begin
                bus_if.b_valid_i = 1'b1; bus_if.b_rd_i = push_rd[s]; bus_if.b_wd_i = push_wd[s];
            end else begin
                bus_if.b_valid_i = 1'b0;
            end
            tick();
            if (s == 0 || s == 4) begin
                n_checks++; if (bus_if.regwrite_o !== 1'b0) begin n_fail++; $display("FAIL b_only_nowrite%0d: got %b want 0", s, bus_if.regwrite_o); end
            end else begin
                n_checks++; if (bus_if.regwrite_o !== 1'b1 || bus_if.rd_o !== exp_rd[s] || bus_if.wd_o !== exp_wd[s]) begin n_fail++; $display("FAIL b_only_w%0d: got rw=%b rd=%0d wd=%h want 1/%0d/%h", s, bus_if.regwrite_o, bus_if.rd_o, bus_if.wd_o, exp_rd[s], exp_wd[s]); end
            end
            n_checks++; if (bus_if.pending_o !== exp_pd[s]) begin n_fail++; $display("FAIL b_only_pend%0d: got %h want %h", s, bus_if.pending_o, exp_pd[s]); end
        end
    endtask

    task automatic test_full();
        logic [4:0] got[$];
        bit         acc;
        do_reset();
        bus_if.a_valid_i = 1'b1; bus_if.a_rd_i = 5'd10; bus_if.a_wd_i = 32'hA0A0;
        for (int i = 0; i < DEPTH; i++) begin
            bus_if.b_valid_i = 1'b1; bus_if.b_rd_i = 5'(11 + i); bus_if.b_wd_i = 32'(i);
            n_checks++; if (bus_if.b_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_ready%0d: got %b want 1", i, bus_if.b_ready_o); end
            tick();
        end
        bus_if.b_rd_i = 5'd15; bus_if.b_wd_i = 32'h55;
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (bus_if.b_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_notready%0d: got %b want 0", i, bus_if.b_ready_o); end
            tick();
        end
        bus_if.a_valid_i = 1'b0;
        for (int t = 0; t < 20 && got.size() < 5; t++) begin
            acc = bus_if.b_valid_i && bus_if.b_ready_o;
            tick();
            if (acc) bus_if.b_valid_i = 1'b0;
            if (bus_if.regwrite_o && bus_if.rd_o != 5'd10) got.push_back(bus_if.rd_o);
        end
        n_checks++; if (got.size() != 5) begin n_fail++; $display("FAIL full_count: got %0d writes want 5", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            n_checks++; if (got[i] !== 5'(11 + i)) begin n_fail++; $display("FAIL full_order%0d: got %0d want %0d", i, got[i], 11 + i); end
        end
        idle_inputs();
    endtask

    task automatic test_starvation();
        do_reset();
        bus_if.a_valid_i = 1'b1; bus_if.a_rd_i = 5'd20; bus_if.a_wd_i = 32'h2020;
        bus_if.b_valid_i = 1'b1; bus_if.b_rd_i = 5'd21; bus_if.b_wd_i = 32'h2121;
        tick();
        bus_if.b_valid_i = 1'b0;
        for (int k = 1; k <= STARVE_MAX; k++) begin
            n_checks++; if (bus_if.a_ready_o !== 1'b1) begin n_fail++; $display("FAIL starve_wait%0d: a_ready got %b want 1", k, bus_if.a_ready_o); end
            tick();
            n_checks++; if (bus_if.rd_o !== 5'd20 || bus_if.regwrite_o !== 1'b1) begin n_fail++; $display("FAIL starve_a%0d: got rw=%b rd=%0d want 1/20", k, bus_if.regwrite_o, bus_if.rd_o); end
        end
        n_checks++; if (bus_if.a_ready_o !== 1'b0) begin n_fail++; $display("FAIL starve_block: a_ready got %b want 0", bus_if.a_ready_o); end
        tick();
        n_checks++; if (bus_if.regwrite_o !== 1'b1 || bus_if.rd_o !== 5'd21 || bus_if.wd_o !== 32'h2121) begin n_fail++; $display("FAIL starve_b: got rw=%b rd=%0d wd=%h want 1/21/2121", bus_if.regwrite_o, bus_if.rd_o, bus_if.wd_o); end
        n_checks++; if (bus_if.a_ready_o !== 1'b1) begin n_fail++; $display("FAIL starve_resume_ready: got %b want 1", bus_if.a_ready_o); end
        tick();
        n_checks++; if (bus_if.rd_o !== 5'd20 || bus_if.regwrite_o !== 1'b1) begin n_fail++; $display("FAIL starve_resume: got rw=%b rd=%0d want 1/20", bus_if.regwrite_o, bus_if.rd_o); end
        idle_inputs();
    endtask

    task automatic test_x0_drop();
        do_reset();
        bus_if.a_valid_i = 1'b1; bus_if.a_rd_i = 5'd0; bus_if.a_wd_i = 32'hBAD0;
        bus_if.b_valid_i = 1'b1; bus_if.b_rd_i = 5'd0; bus_if.b_wd_i = 32'hBAD1;
        n_checks++; if (bus_if.a_ready_o !== 1'b1 || bus_if.b_ready_o !== 1'b1) begin n_fail++; $display("FAIL x0_ready: got a=%b b=%b want 1/1", bus_if.a_ready_o, bus_if.b_ready_o); end
        tick();
        idle_inputs();
        n_checks++; if (bus_if.regwrite_o !== 1'b0) begin n_fail++; $display("FAIL x0_nowrite: got %b want 0", bus_if.regwrite_o); end
        n_checks++; if (bus_if.pending_o !== 32'd0 || bus_if.b_ready_o !== 1'b1) begin n_fail++; $display("FAIL x0_fifo: got pend=%h b_ready=%b want 0/1", bus_if.pending_o, bus_if.b_ready_o); end
        tick();
        n_checks++; if (bus_if.regwrite_o !== 1'b0) begin n_fail++; $display("FAIL x0_nopop: got %b want 0", bus_if.regwrite_o); end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus_if.a_valid_i = 1'b1; bus_if.a_rd_i = 5'd4; bus_if.a_wd_i = 32'h44;
        for (int i = 1; i <= 3; i++) begin
            bus_if.b_valid_i = 1'b1; bus_if.b_rd_i = 5'(i); bus_if.b_wd_i = 32'(i);
            tick();
        end
        n_checks++; if (bus_if.regwrite_o !== 1'b1 || bus_if.pending_o !== 32'h1E) begin n_fail++; $display("FAIL arst_pre: got rw=%b pend=%h want 1/1e", bus_if.regwrite_o, bus_if.pending_o); end
        #2;
        reset_i = 1'b0;
        #1;
        n_checks++; if (bus_if.regwrite_o !== 1'b0 || bus_if.rd_o !== 5'd0 || bus_if.wd_o !== 32'd0) begin n_fail++; $display("FAIL arst_out: got rw=%b rd=%0d wd=%h want 0/0/0", bus_if.regwrite_o, bus_if.rd_o, bus_if.wd_o); end
        n_checks++; if (bus_if.pending_o !== 32'd0 || bus_if.b_ready_o !== 1'b1 || bus_if.a_ready_o !== 1'b1) begin n_fail++; $display("FAIL arst_state: got pend=%h a=%b b=%b want 0/1/1", bus_if.pending_o, bus_if.a_ready_o, bus_if.b_ready_o); end
        idle_inputs();
        model_clear();
        #1;
        reset_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (bus_if.regwrite_o !== 1'b0 || bus_if.pending_o !== 32'd0) begin n_fail++; $display("FAIL arst_stale%0d: got rw=%b pend=%h want 0/0", i, bus_if.regwrite_o, bus_if.pending_o); end
        end
    endtask

    task automatic test_random();
        bit a_hold, b_hold;
        int a_pct;
        a_hold = 1'b0;
        b_hold = 1'b0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            a_pct = (c < 300) ? 55 : 92;
            if (!a_hold) begin
                bus_if.a_valid_i = ($urandom_range(0, 99) < a_pct);
                bus_if.a_rd_i    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                bus_if.a_wd_i    = $urandom();
            end
            if (!b_hold) begin
                bus_if.b_valid_i = ($urandom_range(0, 99) < 45);
                bus_if.b_rd_i    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                bus_if.b_wd_i    = $urandom();
            end
            n_checks++; if (bus_if.a_ready_o !== !((mq.size() != 0) && (m_wait >= STARVE_MAX))) begin n_fail++; $display("FAIL rnd_a_ready c=%0d: got %b", c, bus_if.a_ready_o); end
            n_checks++; if (bus_if.b_ready_o !== (mq.size() != DEPTH)) begin n_fail++; $display("FAIL rnd_b_ready c=%0d: got %b want %b", c, bus_if.b_ready_o, mq.size() != DEPTH); end
            tick();
            a_hold = bus_if.a_valid_i && !last_a_acc;
            b_hold = bus_if.b_valid_i && !last_b_acc;
            n_checks++; if (bus_if.regwrite_o !== m_rw) begin n_fail++; $display("FAIL rnd_regwrite c=%0d: got %b want %b", c, bus_if.regwrite_o, m_rw); end
            if (m_rw) begin
                n_checks++; if (bus_if.rd_o !== m_rd || bus_if.wd_o !== m_wd) begin n_fail++; $display("FAIL rnd_data c=%0d: got rd=%0d wd=%h want %0d/%h", c, bus_if.rd_o, bus_if.wd_o, m_rd, m_wd); end
            end
            n_checks++; if (bus_if.pending_o !== model_pending()) begin n_fail++; $display("FAIL rnd_pending c=%0d: got %h want %h", c, bus_if.pending_o, model_pending()); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_a_only();
        test_b_only();
        test_full();
        test_starvation();
        test_x0_drop();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
